// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Execute-stage sequencer for the multi-cycle radix-2 divider. It accepts a
// DIV/DIVU request from the pipeline and stalls the pipeline while the
// divider runs. It drives the divider's start/annul handshake, including the
// one-cycle start drop that returns the divider to its free state. It writes
// HI/LO for one cycle when the result is ready. A pipeline flush or a
// watchdog timeout aborts the operation.
//
// Parameters:
//   ABORT_CYCLES  cycles for which start=0/annul=1 are held after an abort
//   TIMEOUT       maximum BUSY cycles without dv_ready_i before a forced abort
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   div_req_i           EX stage holds a DIV/DIVU instruction
//   div_op_i            operation code, passed through to the divider
//   div_op1_i/op2_i     dividend / divisor
//   flush_i             pipeline flush (exception or redirect)
//   stall_o             pipeline stall request (combinational)
//   hilo_we_o           one-cycle HI/LO write strobe (combinational)
//   hi_o / lo_o         remainder / quotient, valid while hilo_we_o=1
//   err_o               sticky watchdog error, cleared only by rst
//   dv_start_o          divider start_i
//   dv_annul_o          divider annul_i
//   dv_op_o             divider op
//   dv_opdata1_o/2_o    divider operands, captured on issue
//   dv_result_i         divider result {remainder, quotient}
//   dv_ready_i          divider result ready
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int ABORT_CYCLES = 3,
    parameter int TIMEOUT      = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic [7:0]  div_op_i,
    input  logic [31:0] div_op1_i,
    input  logic [31:0] div_op2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o,
    output logic        dv_start_o,
    output logic        dv_annul_o,
    output logic [7:0]  dv_op_o,
    output logic [31:0] dv_opdata1_o,
    output logic [31:0] dv_opdata2_o,
    input  logic [63:0] dv_result_i,
    input  logic        dv_ready_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int AB_W  = $clog2(ABORT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN,
        S_ABORT
    } state_e;

    state_e      state_q, state_d;
    logic        dv_start_q, dv_start_d;
    logic        dv_annul_q, dv_annul_d;
    logic [7:0]  dv_op_q, dv_op_d;
    logic [31:0] opdata1_q, opdata1_d;
    logic [31:0] opdata2_q, opdata2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AB_W-1:0]  ab_q, ab_d;
    logic        err_q, err_d;
    logic        req_ok;

    // A request flushed in the same cycle is never started.
    assign req_ok = div_req_i & ~flush_i;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        dv_start_d = dv_start_q;
        dv_annul_d = dv_annul_q;
        dv_op_d    = dv_op_q;
        opdata1_d  = opdata1_q;
        opdata2_d  = opdata2_q;
        cnt_d      = cnt_q;
        ab_d       = ab_q;
        err_d      = err_q;
        stall_o    = 1'b0;
        hilo_we_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_o = req_ok;
                if (req_ok) begin
                    dv_op_d    = div_op_i;
                    opdata1_d  = div_op1_i;
                    opdata2_d  = div_op2_i;
                    dv_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_BUSY;
                end
            end

            S_BUSY: begin
                stall_o = ~dv_ready_i;
                cnt_d   = cnt_q + CNT_W'(1);
                // Flush outranks a coincident ready: the result is dropped.
                if (flush_i) begin
                    dv_start_d = 1'b0;
                    dv_annul_d = 1'b1;
                    ab_d       = '0;
                    state_d    = S_ABORT;
                end else if (dv_ready_i) begin
                    hilo_we_o  = 1'b1;
                    dv_start_d = 1'b0;
                    state_d    = S_DRAIN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th BUSY cycle without a result.
                    err_d      = 1'b1;
                    dv_start_d = 1'b0;
                    dv_annul_d = 1'b1;
                    ab_d       = '0;
                    state_d    = S_ABORT;
                end
            end

            S_DRAIN: begin
                // start is low for this cycle, so the divider returns to free.
                // A waiting request issues from IDLE on the next cycle.
                stall_o = div_req_i;
                state_d = S_IDLE;
            end

            S_ABORT: begin
                stall_o = req_ok;
                ab_d    = ab_q + AB_W'(1);
                if (ab_q == AB_W'(ABORT_CYCLES - 1)) begin
                    dv_annul_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            stall_o   = 1'b0;
            hilo_we_o = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dv_start_q <= 1'b0;
            dv_annul_q <= 1'b0;
            dv_op_q    <= '0;
            opdata1_q  <= '0;
            opdata2_q  <= '0;
            cnt_q      <= '0;
            ab_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dv_start_q <= dv_start_d;
            dv_annul_q <= dv_annul_d;
            dv_op_q    <= dv_op_d;
            opdata1_q  <= opdata1_d;
            opdata2_q  <= opdata2_d;
            cnt_q      <= cnt_d;
            ab_q       <= ab_d;
            err_q      <= err_d;
        end
    end

    // Result outputs are zero except during the write strobe.
    assign hi_o         = hilo_we_o ? dv_result_i[63:32] : '0;
    assign lo_o         = hilo_we_o ? dv_result_i[31:0]  : '0;
    assign err_o        = err_q;
    assign dv_start_o   = dv_start_q;
    assign dv_annul_o   = dv_annul_q;
    assign dv_op_o      = dv_op_q;
    assign dv_opdata1_o = opdata1_q;
    assign dv_opdata2_o = opdata2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_req = 1'b0;
    logic [7:0]  div_op = '0;
    logic [31:0] div_op1 = '0;
    logic [31:0] div_op2 = '0;
    logic        flush = 1'b0;
    logic [63:0] dv_result = '0;
    logic        dv_ready = 1'b0;

    logic        stall_o, hilo_we_o, err_o, dv_start_o, dv_annul_o;
    logic [31:0] hi_o, lo_o, dv_opdata1_o, dv_opdata2_o;
    logic [7:0]  dv_op_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .div_req_i    (div_req),
        .div_op_i     (div_op),
        .div_op1_i    (div_op1),
        .div_op2_i    (div_op2),
        .flush_i      (flush),
        .stall_o      (stall_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .err_o        (err_o),
        .dv_start_o   (dv_start_o),
        .dv_annul_o   (dv_annul_o),
        .dv_op_o      (dv_op_o),
        .dv_opdata1_o (dv_opdata1_o),
        .dv_opdata2_o (dv_opdata2_o),
        .dv_result_i  (dv_result),
        .dv_ready_i   (dv_ready)
    );

    // Reference arithmetic: {remainder, quotient}; divide by zero yields 0.
    function automatic logic [63:0] ref_div(input logic [7:0] op,
                                            input logic [31:0] a, b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (op == OP_DIV) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural divider: ready m_lat cycles after it first sees start, held
    // until start drops; annul or start low returns it to free.
    int m_lat   = 0;
    bit m_never = 1'b0;
    int m_cnt   = 0;
    always @(posedge clk) begin
        #1;
        if (dv_start_o && !dv_annul_o) begin
            if (!m_never && m_cnt >= m_lat) begin
                dv_ready  = 1'b1;
                dv_result = ref_div(dv_op_o, dv_opdata1_o, dv_opdata2_o);
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt     = 0;
            dv_ready  = 1'b0;
            dv_result = '0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // One isolated divide: request held until the write is seen, then dropped.
    task automatic do_div(input logic [7:0] op, input logic [31:0] a, b,
                          input int lat, output logic [31:0] hi, lo,
                          output int nwr, wcyc, nstall);
        m_lat = lat;
        nwr = 0; wcyc = -1; nstall = 0; hi = '0; lo = '0;
        @(negedge clk);
        div_req = 1'b1; div_op = op; div_op1 = a; div_op2 = b;
        #1;
        for (int c = 0; c < 300 && wcyc < 0; c++) begin
            if (stall_o) nstall++;
            if (hilo_we_o) begin
                nwr++; wcyc = c; hi = hi_o; lo = lo_o;
            end else begin
                cyc();
            end
        end
        @(negedge clk);
        div_req = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (hilo_we_o) nwr++;
            cyc();
        end
    endtask

    task automatic check_div(input string tag, input logic [31:0] hi, lo,
                             exp_hi, exp_lo, input int nwr, wcyc, nstall, lat);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
        check({tag, ".writes"}, nwr, 1);
        check({tag, ".wr_cycle"}, wcyc, lat + 1);
        check({tag, ".stall_cycles"}, nstall, lat + 1);
    endtask

    task automatic wait_start(input string tag);
        int c;
        c = 0;
        while (!dv_start_o && c < 20) begin c++; cyc(); end
        check({tag, ".start_seen"}, dv_start_o, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"}, stall_o, 1'b0);
        check({tag, ".hilo_we"}, hilo_we_o, 1'b0);
        check({tag, ".hilo"}, {hi_o, lo_o}, 64'd0);
        check({tag, ".err"}, err_o, 1'b0);
        check({tag, ".start_annul"}, {dv_start_o, dv_annul_o}, 2'b00);
        check({tag, ".dv_data"}, {dv_op_o, dv_opdata1_o, dv_opdata2_o}, '0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [31:0] hi, lo;
        int nwr, wcyc, nstall, n, wr;
        bit got;

        vecs[0] = '{OP_DIVU, 32'd7,          32'd2,          3,  32'd1,          32'd3};
        vecs[1] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          35, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
        vecs[2] = '{OP_DIVU, 32'd5,          32'd0,          1,  32'd0,          32'd0};
        vecs[3] = '{OP_DIVU, 32'd100,        32'd7,          0,  32'd2,          32'd14};
        vecs[4] = '{OP_DIV,  32'd100,        32'hFFFF_FFF9,  2,  32'd2,          32'hFFFF_FFF2};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("post_reset");

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            do_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, hi, lo, nwr, wcyc, nstall);
            check_div($sformatf("vec%0d", i), hi, lo, vecs[i].hi, vecs[i].lo,
                      nwr, wcyc, nstall, vecs[i].lat);
        end

        // Back-to-back DIVU 100/7 then 9/3 with the request held throughout.
        m_lat = 4;
        @(negedge clk);
        div_req = 1'b1; div_op = OP_DIVU; div_op1 = 32'd100; div_op2 = 32'd7;
        #1;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (hilo_we_o) begin
                got = 1'b1;
                check("b2b1.hilo", {hi_o, lo_o}, {32'd2, 32'd14});
            end else cyc();
        end
        check("b2b1.seen", got, 1'b1);
        @(negedge clk);
        div_op1 = 32'd9; div_op2 = 32'd3;
        #1;
        n = 0;
        for (int c = 0; c < 10 && !dv_start_o; c++) begin
            n++;
            check($sformatf("b2b.gap_stall%0d", c), stall_o, 1'b1);
            cyc();
        end
        check("b2b.gap_cycles", n, 2);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (hilo_we_o) begin
                got = 1'b1;
                check("b2b2.hilo", {hi_o, lo_o}, {32'd0, 32'd3});
            end else cyc();
        end
        check("b2b2.seen", got, 1'b1);
        @(negedge clk);
        div_req = 1'b0;
        repeat (3) cyc();

        // Flush ten cycles into BUSY, then a fresh divide.
        m_lat = 40;
        @(negedge clk);
        div_req = 1'b1; div_op = OP_DIVU; div_op1 = 32'd1000; div_op2 = 32'd3;
        #1;
        wait_start("flush");
        repeat (9) cyc();
        @(negedge clk);
        flush = 1'b1; div_req = 1'b0;
        #1;
        wr = hilo_we_o;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n = 0;
        for (int c = 0; c < 10 && dv_annul_o; c++) begin
            n++;
            wr += hilo_we_o;
            check($sformatf("flush.start_low%0d", c), dv_start_o, 1'b0);
            cyc();
        end
        check("flush.annul_cycles", n, 3);
        check("flush.writes", wr, 0);
        do_div(OP_DIVU, 32'd5, 32'd5, 3, hi, lo, nwr, wcyc, nstall);
        check_div("after_flush", hi, lo, 32'd0, 32'd1, nwr, wcyc, nstall, 3);

        // Flush in the same cycle as dv_ready_i.
        m_lat = 4;
        @(negedge clk);
        div_req = 1'b1; div_op = OP_DIVU; div_op1 = 32'd20; div_op2 = 32'd3;
        #1;
        for (int c = 0; c < 50 && !dv_ready; c++) cyc();
        check("flushrdy.ready_seen", dv_ready, 1'b1);
        flush = 1'b1; div_req = 1'b0;
        #1;
        check("flushrdy.no_write", hilo_we_o, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flushrdy.abort", {dv_start_o, dv_annul_o}, 2'b01);
        wr = 0;
        for (int c = 0; c < 6; c++) begin wr += hilo_we_o; cyc(); end
        check("flushrdy.writes", wr, 0);

        // Watchdog: divider never ready.
        m_never = 1'b1;
        @(negedge clk);
        div_req = 1'b1; div_op = OP_DIVU; div_op1 = 32'd8; div_op2 = 32'd2;
        #1;
        wait_start("tmo");
        n = 0;
        for (int c = 0; c < 200 && dv_start_o; c++) begin
            n++;
            check($sformatf("tmo.err_low%0d", c), err_o, 1'b0);
            cyc();
        end
        check("tmo.busy_cycles", n, 63);
        check("tmo.err", err_o, 1'b1);
        n = 0;
        for (int c = 0; c < 10 && dv_annul_o; c++) begin
            n++;
            check($sformatf("tmo.abort_stall%0d", c), stall_o, 1'b1);
            cyc();
        end
        check("tmo.annul_cycles", n, 3);
        m_never = 1'b0;
        m_lat = 2;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (hilo_we_o) begin
                got = 1'b1;
                check("tmo.reissue_hilo", {hi_o, lo_o}, {32'd0, 32'd4});
            end else cyc();
        end
        check("tmo.reissue_seen", got, 1'b1);
        check("tmo.err_sticky", err_o, 1'b1);
        @(negedge clk);
        div_req = 1'b0;
        repeat (3) cyc();

        // Reset in the middle of BUSY.
        m_lat = 40;
        @(negedge clk);
        div_req = 1'b1; div_op = OP_DIV; div_op1 = 32'd50; div_op2 = 32'd5;
        #1;
        wait_start("rstmid");
        repeat (4) cyc();
        @(negedge clk);
        rst = 1'b1; div_req = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("rstmid");
        @(negedge clk);
        rst = 1'b0;
        do_div(OP_DIVU, 32'd50, 32'd5, 2, hi, lo, nwr, wcyc, nstall);
        check_div("after_rst", hi, lo, 32'd0, 32'd10, nwr, wcyc, nstall, 2);

        // Randomized divides against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            logic [7:0]  op;
            logic [31:0] a, b;
            logic [63:0] exp;
            int lat;
            op  = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            lat = $urandom_range(0, 40);
            exp = ref_div(op, a, b);
            do_div(op, a, b, lat, hi, lo, nwr, wcyc, nstall);
            check_div($sformatf("rnd%0d", i), hi, lo, exp[63:32], exp[31:0],
                      nwr, wcyc, nstall, lat);
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage sequencer for the multi-cycle radix-2 divider.
- Accepts DIV/DIVU requests from the pipeline and holds the pipeline stalled while the divider runs.
- Drives the divider's start/annul handshake, including the mandatory start-drop that returns the divider to free.
- Issues a one-cycle HI/LO write on completion; aborts cleanly on pipeline flush or on watchdog timeout.

Parameters:
- ABORT_CYCLES, 3, cycles start=0/annul=1 are held after an abort; covers the divider's longest path back to free (DivByZero->DivEnd->Free).
- TIMEOUT, 63, max BUSY cycles waiting for div_ready_i before a forced abort; nominal divide is about 35.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- div_req_i  in  1  EX stage holds a DIV/DIVU instruction
- div_op_i  in  8  `DIV_CONTROL or `DIVU_CONTROL
- div_op1_i  in  32  dividend
- div_op2_i  in  32  divisor
- flush_i  in  1  pipeline flush (exception or redirect)
- stall_o  out  1  pipeline stall request (combinational)
- hilo_we_o  out  1  HI/LO write strobe (combinational, 1 cycle)
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- err_o  out  1  sticky watchdog error
- dv_start_o  out  1  divider start_i
- dv_annul_o  out  1  divider annul_i
- dv_op_o  out  8  divider op
- dv_opdata1_o  out  32  divider opdata1_i
- dv_opdata2_o  out  32  divider opdata2_i
- dv_result_i  in  64  divider result {remainder, quotient}
- dv_ready_i  in  1  divider result ready

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, dv_start_o=0, dv_annul_o=0, dv_op_o/dv_opdata*_o=0, busy counter=0, err_o=0. Combinational outputs evaluate to 0.
- States: IDLE, BUSY, DRAIN, ABORT.
- IDLE:
  - stall_o = div_req_i & ~flush_i.
  - If div_req_i & ~flush_i: register op and operands onto dv_* outputs, set dv_start_o=1, clear counter, go BUSY.
  - flush_i in the same cycle blocks the start.
- BUSY:
  - dv_start_o held 1 and operands held stable.
  - Counter increments every cycle.
  - stall_o = ~dv_ready_i.
  - Priority order, highest first:
    1. flush_i=1: go ABORT. Set dv_start_o=0 and dv_annul_o=1. No HI/LO write, even if dv_ready_i=1 in the same cycle.
    2. dv_ready_i=1: hilo_we_o=1, hi_o=dv_result_i[63:32], lo_o=dv_result_i[31:0] this same cycle. Set dv_start_o=0, go DRAIN.
    3. Counter reaches TIMEOUT: set err_o=1, go ABORT. stall_o stays 1 until the abort completes.
- DRAIN:
  - Lasts 1 cycle with dv_start_o=0, so the divider returns to DivFree.
  - stall_o = div_req_i. A new request cannot issue here; it issues from IDLE on the next cycle.
  - Back-to-back divides are therefore separated by exactly 2 non-BUSY cycles.
- ABORT:
  - dv_start_o=0 and dv_annul_o=1 for ABORT_CYCLES cycles, then dv_annul_o=0 and go IDLE.
  - dv_ready_i is ignored.
  - stall_o = div_req_i & ~flush_i.
  - If the abort came from a timeout and no flush occurred, the request re-issues from IDLE.
- Divide by zero gets no special handling: the divider returns {0,0}, which is written as hi=0, lo=0.
- err_o clears only on rst.
- hilo_we_o is asserted only in BUSY with dv_ready_i=1 and flush_i=0, never twice per issue.
- dv_op_o/dv_opdata*_o change only on the IDLE->BUSY transition.

Test Plan:
- DIVU 7/2, no flush -> stall_o high from the request cycle until the ready cycle; one hilo_we_o pulse with hi=1, lo=3; dv_start_o low for exactly 1 DRAIN cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Two back-to-back DIVU (100/7, then 9/3) -> two hilo_we_o pulses (hi=2, lo=14; then hi=0, lo=3); second dv_start_o rises 2 cycles after the first completion.
- flush_i 10 cycles into BUSY -> no hilo_we_o; dv_annul_o high for 3 cycles; a new DIVU 5/5 then completes with lo=1, hi=0.
- Divide by zero (DIVU 5/0), and separately flush coincident with dv_ready_i -> first gives hi=0, lo=0 with one write; second gives no write and state goes to ABORT.
- Bench divider model that never asserts ready -> err_o=1 after 63 BUSY cycles, ABORT, re-issue; rst mid-BUSY -> all outputs 0 and state IDLE next cycle.
